// File: rtl/divisor_pkg.sv
// divisor_pkg: shared constants for the restoring divider datapath and its control FSM.
package divisor_pkg;
  localparam int DEF_WIDTH = 8;
  localparam logic [1:0] SAL_NADA = 2'b00;
  localparam logic [1:0] SAL_UNO  = 2'b01;
  localparam logic [1:0] SAL_CERO = 2'b10;
endpackage

// File: rtl/divisor_resta.sv
// divisor_resta: combinational compare/subtract of the partial remainder against the divisor.
module divisor_resta #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   i_r,
  input  logic [WIDTH-1:0] i_v,
  output logic             o_mayor,
  output logic [WIDTH:0]   o_dif
);
  assign o_mayor = i_r >= {1'b0, i_v};
  assign o_dif   = i_r - {1'b0, i_v};
endmodule

// File: rtl/divisor_datapath.sv
// divisor_datapath: restoring-division registers executing bajar/igualar/salida commands
// from the control FSM and reporting termino/mayor back to it.
module divisor_datapath
  import divisor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bajar,
  input  logic             igualar,
  input  logic [1:0]       salida,
  output logic             termino,
  output logic             mayor,
  output logic             ocupado,
  output logic             listo,
  output logic             div_cero,
  output logic [WIDTH-1:0] cociente,
  output logic [WIDTH-1:0] residuo
);
  logic [WIDTH-1:0] r_d, r_v, r_q, r_coc, r_res;
  logic [WIDTH:0]   r_r;
  logic [CNT_W-1:0] r_bits, r_qbits;
  logic             r_ocup, r_listo, r_cero;
  logic [WIDTH:0]   w_dif, w_r_new;
  logic [WIDTH-1:0] w_q_new;
  logic             w_mayor, w_bajar, w_resta, w_sal;

  divisor_resta #(.WIDTH(WIDTH)) u_resta (
    .i_r(r_r), .i_v(r_v), .o_mayor(w_mayor), .o_dif(w_dif)
  );

  // bajar only takes priority when it actually shifts; an ignored bajar drops nothing
  assign w_bajar = r_ocup && bajar && r_bits != '0;
  assign w_resta = r_ocup && !w_bajar && igualar && w_mayor;
  assign w_sal   = r_ocup && !w_bajar && (salida == SAL_UNO || salida == SAL_CERO)
                   && r_qbits < CNT_W'(WIDTH);
  assign w_r_new = w_resta ? w_dif : r_r;
  assign w_q_new = {r_q[WIDTH-2:0], salida == SAL_UNO};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d <= '0; r_v <= '0; r_q <= '0; r_r <= '0;
      r_bits <= '0; r_qbits <= '0;
      r_ocup <= 1'b0; r_listo <= 1'b0; r_cero <= 1'b0;
      r_coc <= '0; r_res <= '0;
    end else begin
      r_listo <= 1'b0;
      if (start && !r_ocup) begin
        if (divisor == '0) begin
          r_coc   <= '1;
          r_res   <= dividendo;
          r_cero  <= 1'b1;
          r_listo <= 1'b1;
        end else begin
          r_d     <= dividendo;
          r_v     <= divisor;
          r_r     <= '0;
          r_q     <= '0;
          r_bits  <= CNT_W'(WIDTH);
          r_qbits <= '0;
          r_ocup  <= 1'b1;
          r_cero  <= 1'b0;
        end
      end else if (w_bajar) begin
        r_r    <= {r_r[WIDTH-1:0], r_d[WIDTH-1]};
        r_d    <= r_d << 1;
        r_bits <= r_bits - 1'b1;
      end else begin
        r_r <= w_r_new;
        if (w_sal) begin
          r_q     <= w_q_new;
          r_qbits <= r_qbits + 1'b1;
          if (r_qbits == CNT_W'(WIDTH - 1)) begin
            r_coc   <= w_q_new;
            r_res   <= w_r_new[WIDTH-1:0];
            r_listo <= 1'b1;
            r_ocup  <= 1'b0;
          end
        end
      end
    end
  end

  assign termino  = r_ocup && r_bits == '0;
  assign mayor    = w_mayor;
  assign ocupado  = r_ocup;
  assign listo    = r_listo;
  assign div_cero = r_cero;
  assign cociente = r_coc;
  assign residuo  = r_res;
endmodule

// File: doc/divisor_datapath.md
Name: divisor_datapath

Overview:
- Restoring-division datapath that is paired with the divider control FSM.
- Holds the dividend shift register, the partial remainder, the quotient and the bit counter.
- Executes the FSM commands `bajar`, `igualar` and `salida`, and returns the status flags `termino` and `mayor`.
- Provides the start/done interface to the rest of the divider.

Parameters:
- WIDTH, 8, operand width in bits for dividend, divisor, quotient and remainder.
- CNT_W, $clog2(WIDTH+1), width of the bit counters.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- start  input  1  load operands; honoured only when not ocupado
- dividendo  input  WIDTH  dividend, sampled on accepted start
- divisor  input  WIDTH  divisor, sampled on accepted start
- bajar  input  1  from control: shift next dividend bit into the remainder
- igualar  input  1  from control: remainder <= remainder - divisor
- salida  input  2  from control: 01 append quotient 1, 10 append quotient 0, 00/11 no-op
- termino  output  1  to control: ocupado and bits_left==0 (combinational)
- mayor  output  1  to control: remainder >= divisor (combinational)
- ocupado  output  1  division in progress
- listo  output  1  one-cycle pulse when results are valid
- div_cero  output  1  last accepted operation had divisor==0; held until next accepted start
- cociente  output  WIDTH  registered quotient; holds until next completion
- residuo  output  WIDTH  registered remainder; holds until next completion

Behaviour:
- Reset (rst low, asynchronous):
  - All registers cleared.
  - ocupado=0, listo=0, div_cero=0, cociente=0, residuo=0.
  - termino=0, mayor=1 (remainder 0 >= divisor 0).
- Internal state:
  - D: WIDTH-bit dividend shift register.
  - R: WIDTH+1-bit remainder.
  - V: divisor register.
  - Q: quotient shift register.
  - bits_left and qbits counters.
- Accepted start (start=1, ocupado=0, divisor!=0):
  - D<=dividendo, V<=divisor, R<=0, Q<=0.
  - bits_left<=WIDTH, qbits<=0, ocupado<=1, div_cero<=0.
- Accepted start with divisor==0:
  - No busy phase.
  - Next edge: cociente<=all ones, residuo<=dividendo, div_cero<=1, listo pulses one cycle.
- start while ocupado: ignored; no state change.
- bajar while ocupado and bits_left>0:
  - R<={R[WIDTH-1:0], D[WIDTH-1]}, D<=D<<1, bits_left<=bits_left-1.
  - bajar at bits_left==0 or while idle is ignored.
- igualar while ocupado and mayor=1: R<=R-{1'b0,V}.
  - igualar with mayor=0 is ignored, so the remainder never goes negative.
- salida, only while ocupado and qbits<WIDTH:
  - 01: Q<={Q[WIDTH-2:0],1}, qbits+1.
  - 10: Q<={Q[WIDTH-2:0],0}, qbits+1.
  - 00/11: no effect.
- Simultaneous commands:
  - igualar and salida in the same cycle both apply; this is the normal add_one case.
  - bajar has priority over igualar and salida in the same cycle; the others are dropped.
- Completion: on the edge where qbits reaches WIDTH:
  - cociente<=new Q, residuo<=R[WIDTH-1:0] (post-igualar value if applied that cycle).
  - listo pulses high for the following cycle, and ocupado<=0 on that same edge.
  - termino remains 1 while ocupado until that point.
- Latency: bounded by the control FSM. The datapath adds zero cycles; every command takes effect on the edge where it is sampled.
- Reset mid-operation: aborts immediately; outputs return to reset values and no listo is generated.

Decomposition:
- Shared package divisor_pkg holds:
  - SAL_NADA=2'b00, SAL_UNO=2'b01, SAL_CERO=2'b10.
  - Default WIDTH.
  - The control FSM must also use these constants.
- One natural sub-module: divisor_resta (combinational compare/subtract of R against V; outputs mayor and the difference). Everything else is inline.

Test Plan:
- WIDTH=8, 13/3 driven by the real control FSM -> listo pulse, cociente=4, residuo=1, div_cero=0.
- 255/1 -> cociente=255, residuo=0; 8 bajar pulses and 8 appended 1s observed.
- 5/7 -> cociente=0, residuo=5; igualar never changes R.
- 200/0 -> no ocupado; next cycle listo=1, div_cero=1, cociente=8'hFF, residuo=200.
- Start 100/7, then start 50/5 pulsed mid-operation -> second start ignored; result cociente=14, residuo=2.
- Reset mid-operation:
  - Start 100/7, assert rst low after 3 bajar -> all outputs 0 asynchronously, no listo.
  - After release, 9/2 -> cociente=4, residuo=1.
